arp_cache_multi: RTL and testbench

ARP_CACHE_MULTI -- requirements
Module: arp_cache_multi

---
 rtl/eth_pkg.sv | 16 +
 rtl/arp_cache_multi.sv | 262 ++++++++++++++++++++++++++
 tb/tb_arp_cache_multi.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP types for the ARP cache: address types and the
// cache controller state encoding.
package eth_pkg;

   typedef logic [31:0] ip_addr_t;
   typedef logic [47:0] mac_addr_t;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LEARN_SCAN = 3'd1,
      LEARN_WR   = 3'd2,
      LKP_SCAN   = 3'd3,
      RESP       = 3'd4
   } arp_cache_state_t;

endpackage

// File: rtl/arp_cache_multi.sv
// ARP cache: DEPTH entries of {valid, ip, mac[, age]} held in flop arrays.
// Learn and lookup requests are served by a sequential scan of one entry per
// cycle. Build option ARP_CACHE_AGING_EN adds per-entry age counters, expiry at
// AGE_MAX and oldest-entry victim selection; without it the victim is a
// round-robin pointer and entries never expire.
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high. learn_ready/lkp_ready depend only on FSM state, flush, areset and
// (for lkp_ready) learn_valid. rsp_valid stays high with rsp_hit/rsp_mac stable
// until the edge where rsp_ready is also high.
module arp_cache_multi
   import eth_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int AGE_MAX = 255
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         learn_valid,
   output logic                         learn_ready,
   input  logic [31:0]                  learn_ip,
   input  logic [47:0]                  learn_mac,
   input  logic                         lkp_valid,
   output logic                         lkp_ready,
   input  logic [31:0]                  lkp_ip,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic                         rsp_hit,
   output logic [47:0]                  rsp_mac,
   output logic                         arp_rq_start,
   output logic [31:0]                  arp_rq_ip,
   input  logic                         age_tick,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   entry_count,
   output logic [2:0]                   fsm_state
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);

   // Entry storage
   logic [DEPTH-1:0] valid_q;
   ip_addr_t         ip_q  [DEPTH];
   mac_addr_t        mac_q [DEPTH];

`ifdef ARP_CACHE_AGING_EN
   localparam int AGE_W = $clog2(AGE_MAX+1);
   logic [AGE_W-1:0] age_q [DEPTH];
   logic [AGE_W-1:0] vic_age;
   logic [IDX_W-1:0] vic_idx;
   logic [AGE_W-1:0] nxt_vic_age;
   logic [IDX_W-1:0] nxt_vic_idx;
`else
   logic [IDX_W-1:0] rr_ptr;
   logic             unused_cfg;
   assign unused_cfg = age_tick ^ (AGE_MAX == 0);
`endif

   // Controller registers
   arp_cache_state_t state;
   logic [IDX_W-1:0] idx;
   ip_addr_t         req_ip;
   mac_addr_t        req_mac;
   logic             match_found;
   logic [IDX_W-1:0] match_idx;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;

   // Scan step results and write control
   logic             cur_valid;
   logic             cur_match;
   logic             nxt_match_found;
   logic [IDX_W-1:0] nxt_match_idx;
   logic             nxt_free_found;
   logic [IDX_W-1:0] nxt_free_idx;
   logic             use_victim;
   logic [IDX_W-1:0] victim_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             wr_en;
   logic             learn_fire;
   logic             lkp_fire;
   logic [CNT_W-1:0] valid_cnt;

   assign learn_ready = (state == IDLE) && !flush && !areset;
   assign lkp_ready   = learn_ready && !learn_valid;
   assign learn_fire  = learn_valid && learn_ready;
   assign lkp_fire    = lkp_valid && lkp_ready;
   assign fsm_state   = state;

   // Fold the entry under the scan index into the running scan results
   always_comb begin
      cur_valid       = valid_q[idx];
      cur_match       = cur_valid && (ip_q[idx] == req_ip);
      nxt_match_found = match_found || cur_match;
      nxt_match_idx   = (!match_found && cur_match) ? idx : match_idx;
      nxt_free_found  = free_found || !cur_valid;
      nxt_free_idx    = (!free_found && !cur_valid) ? idx : free_idx;
`ifdef ARP_CACHE_AGING_EN
      nxt_vic_idx     = vic_idx;
      nxt_vic_age     = vic_age;
      // Strict greater-than keeps the lowest index on equal ages
      if ((idx == '0) || (age_q[idx] > vic_age)) begin
         nxt_vic_idx = idx;
         nxt_vic_age = age_q[idx];
      end
`endif
   end

   // Pick the learn target: existing IP, else first free slot, else victim
   always_comb begin
`ifdef ARP_CACHE_AGING_EN
      victim_idx = vic_idx;
`else
      victim_idx = rr_ptr;
`endif
      use_victim = !match_found && !free_found;
      if (match_found)     wr_idx = match_idx;
      else if (free_found) wr_idx = free_idx;
      else                 wr_idx = victim_idx;
      wr_en = (state == LEARN_WR) && !flush && (req_ip != '0);
   end

   // Count valid entries for the registered occupancy output
   always_comb begin
      valid_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_cnt = valid_cnt + CNT_W'(valid_q[i]);
      end
   end

   // Controller FSM with registered response and ARP-request outputs
   always_ff @(posedge aclk) begin
      if (areset) begin
         state        <= IDLE;
         idx          <= '0;
         req_ip       <= '0;
         req_mac      <= '0;
         match_found  <= 1'b0;
         match_idx    <= '0;
         free_found   <= 1'b0;
         free_idx     <= '0;
         rsp_valid    <= 1'b0;
         rsp_hit      <= 1'b0;
         rsp_mac      <= '0;
         arp_rq_start <= 1'b0;
         arp_rq_ip    <= '0;
`ifdef ARP_CACHE_AGING_EN
         vic_idx      <= '0;
         vic_age      <= '0;
`else
         rr_ptr       <= '0;
`endif
      end else begin
         arp_rq_start <= 1'b0;
         if (flush) begin
            // Abandon any request: no write, no response, no ARP request
            state     <= IDLE;
            idx       <= '0;
            rsp_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  idx         <= '0;
                  match_found <= 1'b0;
                  free_found  <= 1'b0;
                  if (learn_fire) begin
                     req_ip  <= learn_ip;
                     req_mac <= learn_mac;
                     state   <= LEARN_SCAN;
                  end else if (lkp_fire) begin
                     req_ip  <= lkp_ip;
                     state   <= LKP_SCAN;
                  end
               end
               LEARN_SCAN: begin
                  match_found <= nxt_match_found;
                  match_idx   <= nxt_match_idx;
                  free_found  <= nxt_free_found;
                  free_idx    <= nxt_free_idx;
`ifdef ARP_CACHE_AGING_EN
                  vic_idx     <= nxt_vic_idx;
                  vic_age     <= nxt_vic_age;
`endif
                  idx <= idx + 1'b1;
                  if (idx == LAST_IDX) state <= LEARN_WR;
               end
               LEARN_WR: begin
`ifndef ARP_CACHE_AGING_EN
                  if (wr_en && use_victim) rr_ptr <= rr_ptr + 1'b1;
`endif
                  state <= IDLE;
               end
               LKP_SCAN: begin
                  match_found <= nxt_match_found;
                  match_idx   <= nxt_match_idx;
                  idx         <= idx + 1'b1;
                  if (idx == LAST_IDX) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_hit   <= nxt_match_found;
                     rsp_mac   <= nxt_match_found ? mac_q[nxt_match_idx] : '0;
                     if (!nxt_match_found) begin
                        arp_rq_start <= 1'b1;
                        arp_rq_ip    <= req_ip;
                     end
                  end
               end
               RESP: begin
                  if (rsp_ready) begin
                     rsp_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Entry array: flush, aging and the learn write (write wins over aging)
   always_ff @(posedge aclk) begin
      if (areset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ip_q[i]  <= '0;
            mac_q[i] <= '0;
`ifdef ARP_CACHE_AGING_EN
            age_q[i] <= '0;
`endif
         end
      end else if (flush) begin
         valid_q <= '0;
      end else begin
`ifdef ARP_CACHE_AGING_EN
         if (age_tick) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i]) begin
                  if (age_q[i] == AGE_W'(AGE_MAX)) valid_q[i] <= 1'b0;
                  else                             age_q[i] <= age_q[i] + 1'b1;
               end
            end
         end
`endif
         if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            ip_q[wr_idx]    <= req_ip;
            mac_q[wr_idx]   <= req_mac;
`ifdef ARP_CACHE_AGING_EN
            age_q[wr_idx]   <= '0;
`endif
         end
      end
   end

   // Occupancy follows valid-bit changes by one cycle
   always_ff @(posedge aclk) begin
      if (areset) entry_count <= '0;
      else        entry_count <= valid_cnt;
   end

endmodule

// File: tb/tb_arp_cache_multi.sv
// Self-checking bench for arp_cache_multi (DEPTH=4, AGE_MAX=3). Expected
// responses and ARP requests are queued by the drivers and checked by a
// monitor. Expected values follow ARP_CACHE_AGING_EN when it is defined.
module tb_arp_cache_multi;

   localparam int DEPTH = 4;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        learn_valid = 1'b0;
   logic        learn_ready;
   logic [31:0] learn_ip = '0;
   logic [47:0] learn_mac = '0;
   logic        lkp_valid = 1'b0;
   logic        lkp_ready;
   logic [31:0] lkp_ip = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_hit;
   logic [47:0] rsp_mac;
   logic        arp_rq_start;
   logic [31:0] arp_rq_ip;
   logic        age_tick = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  entry_count;
   logic [2:0]  fsm_state;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   logic [48:0] exp_q[$];
   logic [31:0] arp_q[$];

`ifdef ARP_CACHE_AGING_EN
   localparam bit AGING = 1'b1;
`else
   localparam bit AGING = 1'b0;
`endif

   arp_cache_multi #(.DEPTH(DEPTH), .AGE_MAX(3)) dut (
      .aclk(aclk), .areset(areset),
      .learn_valid(learn_valid), .learn_ready(learn_ready),
      .learn_ip(learn_ip), .learn_mac(learn_mac),
      .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_ip(lkp_ip),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_hit(rsp_hit), .rsp_mac(rsp_mac),
      .arp_rq_start(arp_rq_start), .arp_rq_ip(arp_rq_ip),
      .age_tick(age_tick), .flush(flush),
      .entry_count(entry_count), .fsm_state(fsm_state)
   );

   // Clock
   always #5 aclk = ~aclk;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Monitor: compares each new response and each ARP request pulse
   initial begin
      logic        in_rsp;
      logic        prev_arp;
      logic [48:0] e;
      logic [31:0] a;
      in_rsp = 1'b0;
      prev_arp = 1'b0;
      forever begin
         @(negedge aclk);
         if (!areset) begin
            if (prev_arp) check("arp_rq_one_cycle", arp_rq_start, 0);
            if (arp_rq_start) begin
               if (arp_q.size() == 0) check("arp_rq_unexpected", 1, 0);
               else begin
                  a = arp_q.pop_front();
                  check("arp_rq_ip", arp_rq_ip, a);
               end
               check("arp_rq_first_rsp_cycle", rsp_valid && !in_rsp, 1);
            end
            if (rsp_valid && !in_rsp) begin
               if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("rsp_hit_mac", {rsp_hit, rsp_mac}, e);
               end
            end
            in_rsp = rsp_valid;
            prev_arp = arp_rq_start;
         end
      end
   end

   task automatic do_learn(input logic [31:0] ip, input logic [47:0] mac);
      int n;
      @(negedge aclk);
      learn_valid = 1'b1; learn_ip = ip; learn_mac = mac;
      #1;
      n = 0;
      while (!learn_ready && n < 50) begin @(negedge aclk); n++; end
      if (!learn_ready) begin
         check("learn_accept_timeout", 0, 1);
         learn_valid = 1'b0;
         return;
      end
      @(posedge aclk); #1 learn_valid = 1'b0;
      n = 0;
      do begin @(negedge aclk); n++; end while (!learn_ready && n < 50);
      check("learn_latency", n, DEPTH + 2);
   endtask

   // Everything after the lookup handshake edge: latency, hold, release
   task automatic finish_lookup(input logic hit, input logic [47:0] mac, input int hold);
      int n;
      n = 0;
      do begin @(negedge aclk); n++; end while (!rsp_valid && n < 50);
      check("rsp_latency", n, DEPTH + 1);
      for (int k = 0; k < hold; k++) begin
         @(negedge aclk);
         check("rsp_hold", {rsp_valid, rsp_hit, rsp_mac}, {1'b1, hit, hit ? mac : 48'h0});
      end
      rsp_ready = 1'b1;
      @(posedge aclk); #1 rsp_ready = 1'b0;
      @(negedge aclk);
      check("rsp_release", {rsp_valid, fsm_state}, {1'b0, 3'd0});
   endtask

   task automatic do_lookup(input logic [31:0] ip, input logic hit, input logic [47:0] mac, input int hold);
      int n;
      @(negedge aclk);
      lkp_valid = 1'b1; lkp_ip = ip;
      #1;
      n = 0;
      while (!lkp_ready && n < 50) begin @(negedge aclk); n++; end
      if (!lkp_ready) begin
         check("lkp_accept_timeout", 0, 1);
         lkp_valid = 1'b0;
         return;
      end
      exp_q.push_back({hit, hit ? mac : 48'h0});
      if (!hit) arp_q.push_back(ip);
      @(posedge aclk); #1 lkp_valid = 1'b0;
      finish_lookup(hit, mac, hold);
   endtask

   task automatic pulse_tick();
      @(negedge aclk); age_tick = 1'b1;
      @(posedge aclk); #1 age_tick = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge aclk); flush = 1'b1;
      #1 check("ready_during_flush", {learn_ready, lkp_ready}, 2'b00);
      @(posedge aclk); #1 flush = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic check_count(input string name);
      repeat (2) @(negedge aclk);
      check(name, entry_count, exp_cnt);
   endtask

   // Directed stimulus
   initial begin
      int n;
      // Reset with requests pending: nothing may be accepted
      learn_valid = 1'b1; lkp_valid = 1'b1;
      repeat (3) @(negedge aclk);
      check("reset_ready", {learn_ready, lkp_ready}, 2'b00);
      check("reset_outputs", {rsp_valid, rsp_hit, arp_rq_start, entry_count, fsm_state}, 0);
      check("reset_data", {rsp_mac, arp_rq_ip[15:0]}, 0);
      learn_valid = 1'b0; lkp_valid = 1'b0;
      areset = 1'b0;
      @(negedge aclk);
      check("post_reset_idle", {fsm_state, learn_ready, lkp_ready}, {3'd0, 2'b11});

      // Learn then hit
      do_learn(32'hC0A8010A, 48'h001122334455);
      exp_cnt = 1;
      check_count("count_after_learn");
      do_lookup(32'hC0A8010A, 1'b1, 48'h001122334455, 0);

      // Miss on empty cache, response held with rsp_ready low
      pulse_flush();
      check_count("count_after_flush");
      do_lookup(32'hC0A80163, 1'b0, 48'h0, 10);

      // Fill, age once, replace on tie at lowest index
      pulse_flush();
      for (int i = 1; i <= 4; i++) do_learn(32'hC0A80100 + i, 48'h020000000000 + i);
      exp_cnt = 4;
      check_count("count_full");
      pulse_tick();
      do_learn(32'hC0A80105, 48'h020000000005);
      check_count("count_after_replace");
      do_lookup(32'hC0A80101, 1'b0, 48'h0, 0);
      do_lookup(32'hC0A80105, 1'b1, 48'h020000000005, 0);
      do_lookup(32'hC0A80102, 1'b1, 48'h020000000002, 1);

      // Expiry after AGE_MAX+1 ticks
      pulse_flush();
      do_learn(32'hC0A80101, 48'h0A0B0C0D0E01);
      exp_cnt = 1;
      for (int i = 0; i < 3; i++) pulse_tick();
      check_count("count_before_expiry");
      pulse_tick();
      exp_cnt = AGING ? 0 : 1;
      check_count("count_after_expiry");
      do_lookup(32'hC0A80101, !AGING, 48'h0A0B0C0D0E01, 0);

      // IP 0 is accepted but never stored
      do_learn(32'h0, 48'hFFFFFFFFFFFF);
      check_count("count_after_ip0");

      // Flush during a lookup scan: no response, back to IDLE
      do_learn(32'hC0A80107, 48'h020000000007);
      exp_cnt = exp_cnt + 1;
      check_count("count_before_midflush");
      @(negedge aclk);
      lkp_valid = 1'b1; lkp_ip = 32'hC0A80107;
      #1 check("midflush_accept", lkp_ready, 1);
      @(posedge aclk); #1 lkp_valid = 1'b0;
      @(posedge aclk);
      @(posedge aclk); #1 flush = 1'b1;
      @(posedge aclk); #1 flush = 1'b0;
      @(negedge aclk);
      check("midflush_state", {fsm_state, rsp_valid}, {3'd0, 1'b0});
      check("midflush_count_lag", entry_count, exp_cnt);
      @(negedge aclk);
      exp_cnt = 0;
      check("midflush_count", entry_count, exp_cnt);
      n = 0;
      for (int k = 0; k < 8; k++) begin @(negedge aclk); n += int'(rsp_valid); end
      check("midflush_no_rsp", n, 0);

      // Simultaneous learn and lookup: learn first, lookup then hits
      @(negedge aclk);
      learn_valid = 1'b1; learn_ip = 32'hC0A80109; learn_mac = 48'h020000000009;
      lkp_valid = 1'b1; lkp_ip = 32'hC0A80109;
      #1 check("priority_ready", {learn_ready, lkp_ready}, 2'b10);
      @(posedge aclk); #1 learn_valid = 1'b0;
      n = 0;
      do begin @(negedge aclk); n++; end while (!lkp_ready && n < 50);
      check("lkp_after_learn_latency", n, DEPTH + 2);
      exp_q.push_back({1'b1, 48'h020000000009});
      @(posedge aclk); #1 lkp_valid = 1'b0;
      finish_lookup(1'b1, 48'h020000000009, 0);
      exp_cnt = 1;
      check_count("count_after_priority");

      // Relearn of a present IP updates the MAC in place
      do_learn(32'hC0A80109, 48'h0C0C0C0C0C0C);
      check_count("count_after_update");
      do_lookup(32'hC0A80109, 1'b1, 48'h0C0C0C0C0C0C, 0);

      repeat (4) @(negedge aclk);
      check("exp_q_drained", exp_q.size(), 0);
      check("arp_q_drained", arp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
